seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Time-multiplexed scan controller for a multi-digit common-anode seven-segment display. Latches a packed BCD value, walks the digits round-robin at a programmable rate, and presents one nibble at a time on `bcd` to the downstream BCD-to-seven-segment decoder. It drives the active-low digit enables in step with that nibble. A short all-off gap between digits suppresses ghosting.

## Interface
- `DIGITS`, 4: number of digits scanned; at least 2.
- `SLOT_CYCLES`, 50000: clock cycles each digit is lit; at least 1.
- `GAP_CYCLES`, 2: clock cycles with all digits off between slots; 0 means no gap.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: when high, capture `value_in` this edge.
- `value_in` in 4*DIGITS: packed BCD; nibble k (bits 4k+3:4k) is digit k; digit 0 is least significant and rightmost.
- `bcd` out 4: nibble for the decoder; 4'hF means blank (the decoder shows all segments off).
- `an` out DIGITS: digit enables, active low; at most one bit is low at any time.
- `digit_idx` out clog2(DIGITS): index of the digit currently selected.

## Operation
- Holding register `value_q` is loaded whenever `load`=1. There is no handshake; a load is accepted on any cycle. The latest value wins.
- FSM states: GAP and SHOW.
  - GAP: `an` is all ones and `bcd`=4'hF. Stays for GAP_CYCLES cycles, then enters SHOW with the current `digit_idx`.
  - SHOW: `an` has bit `digit_idx` low and all other bits high. `bcd` = nibble `digit_idx` of `value_q`. Stays for SLOT_CYCLES cycles.
  - On leaving SHOW, `digit_idx` increments modulo DIGITS (DIGITS-1 wraps to 0) and the FSM enters GAP.
  - If GAP_CYCLES=0, SHOW goes directly to SHOW for the next digit and GAP is never entered.
- One slot counter, wide enough for max(SLOT_CYCLES, GAP_CYCLES)-1, counts 0..N-1 in each state. It clears on every state or digit change.
- Nibbles greater than 9 pass through unchanged; the decoder blanks them.
- A load during SHOW updates `bcd` mid-slot. The slot is not restarted and `digit_idx` is not disturbed.
- `rst` mid-scan aborts the slot immediately, with no completion of the current digit.

## Timing
- All outputs are registered. Reset values: `an` all ones, `bcd`=4'hF, `digit_idx`=0, `value_q`=0, state GAP (or SHOW when GAP_CYCLES=0), slot counter 0.
- After `rst` deasserts, the first SHOW of digit 0 begins GAP_CYCLES cycles later.
- Full scan period is DIGITS*(SLOT_CYCLES+GAP_CYCLES) cycles. Each `an` bit is low for exactly SLOT_CYCLES consecutive cycles per period.
- Load latency: `load` sampled at edge n updates `value_q` at edge n. The new nibble appears on `bcd` at edge n+1 if that digit is in SHOW.
- `an`, `bcd` and `digit_idx` change on the same edge; no cycle shows a stale nibble with a new enable.
- `rst` and `load` in the same cycle: reset wins and `value_q`=0.

## Configuration
- `SEG_SCAN_LZ_BLANK_EN` defined: leading-zero suppression.
  - In SHOW, digit k>0 outputs `bcd`=4'hF when nibbles DIGITS-1 down to k are all zero.
  - `an` still cycles normally.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- Not defined: every nibble is shown verbatim, including leading zeros.
- Timing and latency are identical in both builds.

## Structure
- Shared package holds:
  - the FSM state enum (GAP, SHOW);
  - the blank code constant BCD_BLANK=4'hF;
  - a function for the index width (clog2 of DIGITS).
- One sub-module, `scan_slot_timer`. It holds the slot counter and takes the current state's length. It outputs `slot_done`, high on the last cycle of a slot. The top holds the FSM, `value_q`, the index and the output registers.
- The decoder is not instantiated here; `bcd` connects to it at the display top level.

## Test plan
- Reset and first slot (DIGITS=4, SLOT_CYCLES=4, GAP_CYCLES=2): `an`=4'b1111 and `bcd`=F during reset and for 2 cycles after. Then `an`=4'b1110 for 4 cycles, then 2 gap cycles, then `an`=4'b1101.
- Scan order and wrap: load 16'h1234, run 2 periods. Observed `bcd` sequence is 4,3,2,1,4,3,2,1. `digit_idx` wraps 3→0, and no two `an` bits are ever low together.
- Mid-slot load: load 16'h5678 on cycle 2 of digit 1's SHOW. `bcd` changes 3→7 on the next edge. The slot still ends on its original cycle.
- No gap (GAP_CYCLES=0): the `an` transition 1110→1101 happens in one edge, with no all-ones cycle. Period = 16 cycles.
- Leading-zero blank: with the macro defined, value 16'h0040 gives `bcd` F,F,4,0 on digits 3..0. Value 16'h0000 gives F,F,F,0. Without the macro, the same values give 0,0,4,0 and 0,0,0,0.
- Reset mid-scan: assert `rst` during digit 2's SHOW. The next edge gives `an`=4'b1111, `bcd`=F and `digit_idx`=0. `value_q` reads 0 afterward, so digit 0 then shows 0.

Source files
------------

// File: rtl/seg_scan_mux_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_mux_pkg;

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } scan_state_e;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  function automatic int idx_w(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_mux_timer.sv
// Slot timer: counts 0..len-1 in the current state and flags the last cycle.
module scan_slot_timer #(
  parameter int CW = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [CW:0] slot_len,
  output logic        slot_done
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Every state or digit change happens exactly on slot_done, so that is the only clear.
  assign slot_done = ({1'b0, cnt_q} == (slot_len - (CW+1)'(1)));

  always_comb begin
    cnt_d = slot_done ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Round-robin seven-segment digit scanner with blanking gap between digits.
// Define SEG_SCAN_LZ_BLANK_EN to blank leading zeros (digit 0 is never blanked).
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SLOT_CYCLES = 50000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*DIGITS-1:0]       value_in,
  output logic [3:0]                bcd,
  output logic [DIGITS-1:0]         an,
  output logic [idx_w(DIGITS)-1:0]  digit_idx
);

  localparam int IW   = idx_w(DIGITS);
  localparam int MAXC = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam scan_state_e RST_ST = (GAP_CYCLES == 0) ? ST_SHOW : ST_GAP;

  scan_state_e               state_q, state_d;
  logic [DIGITS-1:0][3:0]    value_q, value_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [DIGITS-1:0]         an_q, an_d;
  logic [3:0]                bcd_q, bcd_d;
  logic [CW:0]               slot_len;
  logic                      slot_done;

  assign slot_len = (state_q == ST_SHOW) ? (CW+1)'(SLOT_CYCLES) : (CW+1)'(GAP_CYCLES);

  scan_slot_timer #(.CW(CW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .slot_len  (slot_len),
    .slot_done (slot_done)
  );

`ifdef SEG_SCAN_LZ_BLANK_EN
  // lz[k]: nibbles DIGITS-1 down to k are all zero.
  logic [DIGITS-1:0] lz;
  always_comb begin
    logic run;
    run = 1'b1;
    lz  = '0;
    for (int k = DIGITS-1; k >= 1; k--) begin
      run   = run & (value_q[k] == 4'd0);
      lz[k] = run;
    end
  end
`endif

  always_comb begin
    value_d = load ? value_in : value_q;
    state_d = state_q;
    idx_d   = idx_q;
    if (slot_done) begin
      if (state_q == ST_SHOW) begin
        idx_d   = (idx_q == IW'(DIGITS-1)) ? '0 : idx_q + IW'(1);
        state_d = (GAP_CYCLES == 0) ? ST_SHOW : ST_GAP;
      end else begin
        state_d = ST_SHOW;
      end
    end
    // Outputs follow the next state so enable, nibble and index switch on one edge.
    an_d  = '1;
    bcd_d = BCD_BLANK;
    if (state_d == ST_SHOW) begin
      an_d[idx_d] = 1'b0;
      bcd_d       = value_q[idx_d];
`ifdef SEG_SCAN_LZ_BLANK_EN
      if (lz[idx_d]) bcd_d = BCD_BLANK;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_ST;
      value_q <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      bcd_q   <= BCD_BLANK;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bcd       = bcd_q;
  assign an        = an_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: gapped and gapless instances against a cycle-count reference model.
module tb_seg_scan_mux;

  localparam int D = 4;
  localparam int S = 4;
  localparam int G = 2;
  localparam int P = D * (S + G);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  bcd, bcd0;
  logic [3:0]  an, an0;
  logic [1:0]  idx, idx0;

  int checks = 0;
  int errors = 0;
  int t = 0;              // cycles since the last reset edge
  logic [15:0] mv = '0;   // model of the holding register
  logic [15:0] src = '0;  // value the outputs were computed from

  always #5 clk = ~clk;

  seg_scan_mux #(.DIGITS(D), .SLOT_CYCLES(S), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in),
    .bcd(bcd), .an(an), .digit_idx(idx)
  );

  seg_scan_mux #(.DIGITS(D), .SLOT_CYCLES(S), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in),
    .bcd(bcd0), .an(an0), .digit_idx(idx0)
  );

  function automatic logic [3:0] nib(input logic [15:0] v, input int k);
    logic [15:0] above;
    above = v >> (4 * k);
`ifdef SEG_SCAN_LZ_BLANK_EN
    if (k > 0 && above == 16'h0) return 4'hF;
`endif
    return above[3:0];
  endfunction

  // Expected outputs at cycle tt from the slot arithmetic of the scan.
  function automatic void exp_out(input int g, input int tt, input logic [15:0] sv,
                                  output logic [3:0] ean, output logic [3:0] eb,
                                  output logic [1:0] ei);
    int per, slot, off;
    ean = 4'hF; eb = 4'hF; ei = 2'd0;
    if (g == 0 && tt == 0) return;
    per  = S + g;
    slot = (tt % (D * per)) / per;
    off  = tt % per;
    ei   = slot[1:0];
    if (off >= g) begin
      ean = ~(4'b0001 << slot);
      eb  = nib(sv, slot);
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic step();
    logic r, l;
    logic [15:0] v;
    logic [3:0] ean, eb;
    logic [1:0] ei;
    r = rst; l = load; v = value_in;
    @(posedge clk);
    if (r) begin
      t = 0; mv = '0; src = '0;
    end else begin
      src = mv;
      if (l) mv = v;
      t++;
    end
    #1;
    exp_out(G, t, src, ean, eb, ei);
    chk("an",  {12'h0, an},  {12'h0, ean});
    chk("bcd", {12'h0, bcd}, {12'h0, eb});
    chk("idx", {14'h0, idx}, {14'h0, ei});
    chk("an_onehot", 16'($countones(~an) <= 1), 16'd1);
    exp_out(0, t, src, ean, eb, ei);
    chk("an_nogap",  {12'h0, an0},  {12'h0, ean});
    chk("bcd_nogap", {12'h0, bcd0}, {12'h0, eb});
    chk("idx_nogap", {14'h0, idx0}, {14'h0, ei});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic align(input string tag, input int pos);
    int n;
    n = 0;
    while ((t % P) != pos && n < 200) begin
      step();
      n++;
    end
    chk(tag, 16'(n < 200), 16'd1);
  endtask

  initial begin
    // Reset held for a few cycles, with a load that must lose to reset.
    rst = 1'b1; load = 1'b1; value_in = 16'h9999;
    run(3);
    load = 1'b0;
    rst = 1'b0;
    run(P + 2);

    // Scan order and wrap.
    load = 1'b1; value_in = 16'h1234;
    step();
    load = 1'b0;
    run(2 * P);

    // Mid-slot load during digit 1's show.
    align("align_mid", G + S + G + 1);
    load = 1'b1; value_in = 16'h5678;
    step();
    load = 1'b0;
    run(P);

    // Leading-zero patterns.
    load = 1'b1; value_in = 16'h0040;
    step();
    load = 1'b0;
    run(P + 1);
    load = 1'b1; value_in = 16'h0000;
    step();
    load = 1'b0;
    run(P + 1);

    // Reset during digit 2's show.
    load = 1'b1; value_in = 16'h4321;
    step();
    load = 1'b0;
    align("align_rst", 2 * (S + G) + G + 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(P + 2);

    // Random loads, values with leading zeros and nibbles above 9, occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] v;
      v = 16'($urandom) >> (4 * $urandom_range(0, 3));
      load     = ($urandom_range(0, 7) == 0);
      value_in = v;
      rst      = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; load = 1'b0;
    run(P);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
